// File: rtl/mode_switch_sequencer_if.sv
// Command strobe from the SPI receiver and the applied mode/divisor fan-out.
// valid/ready: cfg_valid is a one-cycle strobe with no ready; the sequencer always accepts it.
interface mode_switch_sequencer_if;
    logic        cfg_valid;
    logic [15:0] cfg_word;
    logic [7:0]  conf_word;
    logic [2:0]  major_mode;
    logic [7:0]  divisor;
    logic        outputs_quiet;
    logic        busy;
    logic        seq_done;
    logic        pend_overflow;
    logic [1:0]  fsm_state;

    modport master (
        output cfg_valid, cfg_word,
        input  conf_word, major_mode, divisor, outputs_quiet, busy,
        input  seq_done, pend_overflow, fsm_state
    );

    modport slave (
        input  cfg_valid, cfg_word,
        output conf_word, major_mode, divisor, outputs_quiet, busy,
        output seq_done, pend_overflow, fsm_state
    );
endinterface

// File: rtl/mode_switch_sequencer.sv
// Applies SPI configuration commands to the mux8 select/divisor registers,
// running a quiet/switch/settle sequence whenever the major mode changes.
module mode_switch_sequencer #(
    parameter int QUIET_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 32
) (
    input logic                    pck0,
    input logic                    rst,
    mode_switch_sequencer_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] QUIET  = 2'd1;
    localparam logic [1:0] SWITCH = 2'd2;
    localparam logic [1:0] SETTLE = 2'd3;

    localparam logic [3:0] OP_CONF = 4'b0001;
    localparam logic [3:0] OP_DIV  = 4'b0010;

    localparam logic [7:0] QUIET_LOAD  = 8'(QUIET_CYCLES - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    logic [1:0]  state;
    logic [7:0]  count;
    logic [7:0]  target;
    logic [7:0]  conf_q;
    logic [7:0]  div_q;
    logic        done_q;
    logic        ovf_q;
    logic        pend_valid;
    logic        pend_is_div;
    logic [7:0]  pend_payload;

    logic        cfg_ok;
    logic        cfg_is_div;
    logic        cmd_valid;
    logic        cmd_is_div;
    logic [7:0]  cmd_payload;
    logic        unused_bits;

    // Bits [11:8] of the command carry nothing this block uses.
    assign unused_bits = ^bus.cfg_word[11:8];

    assign cfg_is_div = (bus.cfg_word[15:12] == OP_DIV);
    assign cfg_ok     = bus.cfg_valid &&
                        ((bus.cfg_word[15:12] == OP_CONF) || cfg_is_div);

    // In IDLE a waiting pending command takes priority over a fresh strobe.
    always_comb begin
        cmd_valid   = 1'b0;
        cmd_is_div  = 1'b0;
        cmd_payload = 8'd0;
        if (state == IDLE) begin
            if (pend_valid) begin
                cmd_valid   = 1'b1;
                cmd_is_div  = pend_is_div;
                cmd_payload = pend_payload;
            end else if (cfg_ok) begin
                cmd_valid   = 1'b1;
                cmd_is_div  = cfg_is_div;
                cmd_payload = bus.cfg_word[7:0];
            end
        end
    end

    always_ff @(posedge pck0) begin
        if (rst) begin
            state        <= IDLE;
            count        <= 8'd0;
            target       <= 8'hE0;
            conf_q       <= 8'hE0;
            div_q        <= 8'd95;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            pend_valid   <= 1'b0;
            pend_is_div  <= 1'b0;
            pend_payload <= 8'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_is_div) begin
                            div_q <= cmd_payload;
                        end else if (cmd_payload[7:5] == conf_q[7:5]) begin
                            conf_q <= cmd_payload;
                        end else begin
                            target <= cmd_payload;
                            count  <= QUIET_LOAD;
                            state  <= QUIET;
                        end
                    end
                    // Pending consumed this cycle; a simultaneous strobe refills the slot.
                    if (pend_valid) begin
                        pend_valid <= cfg_ok;
                        if (cfg_ok) begin
                            pend_is_div  <= cfg_is_div;
                            pend_payload <= bus.cfg_word[7:0];
                        end
                    end
                end
                QUIET: begin
                    if (count == 8'd0) begin
                        state <= SWITCH;
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                SWITCH: begin
                    conf_q <= target;
                    count  <= SETTLE_LOAD;
                    state  <= SETTLE;
                end
                SETTLE: begin
                    if (count == 8'd0) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            if ((state != IDLE) && cfg_ok) begin
                pend_valid   <= 1'b1;
                pend_is_div  <= cfg_is_div;
                pend_payload <= bus.cfg_word[7:0];
                if (pend_valid) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign bus.conf_word     = conf_q;
    assign bus.major_mode    = conf_q[7:5];
    assign bus.divisor       = div_q;
    assign bus.outputs_quiet = (state != IDLE);
    assign bus.busy          = (state != IDLE);
    assign bus.seq_done      = done_q;
    assign bus.pend_overflow = ovf_q;
    assign bus.fsm_state     = state;
endmodule

// File: tb/tb_mode_switch_sequencer.sv
// Bench for mode_switch_sequencer: directed scenarios then random strobes,
// all checked every cycle against a timeline-based reference model.
module tb_mode_switch_sequencer;
    localparam int Q = 16;
    localparam int S = 32;

    logic pck0;
    logic rst;
    int   checks;
    int   errors;

    mode_switch_sequencer_if bus ();

    mode_switch_sequencer #(.QUIET_CYCLES(Q), .SETTLE_CYCLES(S)) dut (
        .pck0 (pck0),
        .rst  (rst),
        .bus  (bus)
    );

    // ---------------- clock / reset ----------------
    initial pck0 = 1'b0;
    always #5 pck0 = ~pck0;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A mode change accepted at edge e switches the select at e+Q+1 and
    // finishes at e+Q+S+1; outputs are quiet for the whole window.
    int         e;
    logic [7:0] m_conf = 8'hE0;
    logic [7:0] m_div = 8'd95;
    logic [7:0] m_target;
    bit         m_active;
    int         m_switch_e;
    int         m_done_e;
    bit         m_done;
    bit         m_ovf;
    bit         m_pend_v;
    logic [15:0] m_pend_w;
    logic [7:0] exp_q[$];
    logic [7:0] prev_dut_conf = 8'hE0;

    task automatic m_apply(input logic [15:0] w);
        if (w[15:12] == 4'b0010) begin
            m_div = w[7:0];
        end else if (w[7:5] == m_conf[7:5]) begin
            m_conf = w[7:0];
        end else begin
            m_active   = 1'b1;
            m_target   = w[7:0];
            m_switch_e = e + Q + 1;
            m_done_e   = e + Q + S + 1;
        end
    endtask

    always @(posedge pck0) begin
        logic [7:0]  old_conf;
        logic [15:0] w;
        bit was, ok;
        e++;
        old_conf = m_conf;
        if (rst) begin
            m_conf = 8'hE0; m_div = 8'd95; m_active = 0; m_done = 0;
            m_ovf = 0; m_pend_v = 0;
        end else begin
            was    = m_active;
            m_done = 0;
            if (m_active && e == m_switch_e) m_conf = m_target;
            if (m_active && e == m_done_e) begin
                m_active = 0;
                m_done   = 1;
            end
            ok = bus.cfg_valid && (bus.cfg_word[15:12] == 4'b0001 || bus.cfg_word[15:12] == 4'b0010);
            if (was) begin
                if (ok) begin
                    if (m_pend_v) m_ovf = 1;
                    m_pend_v = 1;
                    m_pend_w = bus.cfg_word;
                end
            end else if (m_pend_v) begin
                w = m_pend_w;
                m_pend_v = 0;
                m_apply(w);
                if (ok) begin
                    m_pend_v = 1;
                    m_pend_w = bus.cfg_word;
                end
            end else if (ok) begin
                m_apply(bus.cfg_word);
            end
        end
        if (m_conf != old_conf) exp_q.push_back(m_conf);

        #1;
        check("conf_word", bus.conf_word, m_conf);
        check("major_mode", bus.major_mode, m_conf[7:5]);
        check("divisor", bus.divisor, m_div);
        check("outputs_quiet", bus.outputs_quiet, m_active);
        check("busy", bus.busy, m_active);
        check("seq_done", bus.seq_done, m_done);
        check("pend_overflow", bus.pend_overflow, m_ovf);
        // Scoreboard: every select update must match the next expected value, in order.
        if (bus.conf_word !== prev_dut_conf) begin
            if (exp_q.size() == 0) check("conf_unexpected", bus.conf_word, prev_dut_conf);
            else check("conf_order", bus.conf_word, exp_q.pop_front());
            prev_dut_conf = bus.conf_word;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [15:0] w);
        @(negedge pck0);
        bus.cfg_valid = 1'b1;
        bus.cfg_word  = w;
        @(negedge pck0);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (bus.seq_done !== 1'b1 && n < 200) begin
            @(negedge pck0);
            n++;
        end
        check(tag, bus.seq_done, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int r;
        logic [3:0] op;
        checks = 0;
        errors = 0;
        e = 0;
        rst = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.cfg_word  = 16'h0;
        repeat (2) @(negedge pck0);
        rst = 1'b0;
        repeat (100) @(negedge pck0);
        check("idle_conf", bus.conf_word, 8'hE0);
        check("idle_div", bus.divisor, 8'd95);
        check("idle_busy", bus.busy, 1'b0);

        send(16'h2040);
        check("div_imm", bus.divisor, 8'h40);
        check("div_imm_busy", bus.busy, 1'b0);

        send(16'h1000);
        check("quiet_rise", bus.outputs_quiet, 1'b1);
        n = 1;
        while (bus.major_mode !== 3'b000 && n < 200) begin
            @(negedge pck0);
            n++;
        end
        check("switch_latency", n, 18);
        while (bus.outputs_quiet !== 1'b0 && n < 200) begin
            @(negedge pck0);
            n++;
        end
        check("release_latency", n, 50);
        check("done_at_release", bus.seq_done, 1'b1);
        @(negedge pck0);
        check("done_one_cycle", bus.seq_done, 1'b0);

        send(16'h1008);
        check("same_mode_conf", bus.conf_word, 8'h08);
        check("same_mode_quiet", bus.outputs_quiet, 1'b0);

        send(16'h1040);
        repeat (5) @(negedge pck0);
        send(16'h1060);
        send(16'h2010);
        check("overflow_set", bus.pend_overflow, 1'b1);
        wait_done("ovf_seq_done");
        @(negedge pck0);
        check("pending_div", bus.divisor, 8'h10);
        check("mode_not_011", bus.major_mode, 3'b010);

        send(16'h1000);
        repeat (30) @(negedge pck0);
        rst = 1'b1;
        @(negedge pck0);
        rst = 1'b0;
        check("rst_conf", bus.conf_word, 8'hE0);
        check("rst_div", bus.divisor, 8'd95);
        check("rst_quiet", bus.outputs_quiet, 1'b0);
        check("rst_done", bus.seq_done, 1'b0);
        check("rst_ovf", bus.pend_overflow, 1'b0);

        for (int i = 0; i < 5000; i++) begin
            @(negedge pck0);
            r = $urandom_range(0, 199);
            rst = (r == 0);
            bus.cfg_valid = 1'b0;
            if (r > 0 && r < 14) begin
                case ($urandom_range(0, 3))
                    0, 1:    op = 4'b0001;
                    2:       op = 4'b0010;
                    default: op = 4'($urandom_range(0, 15));
                endcase
                bus.cfg_valid = 1'b1;
                bus.cfg_word  = {op, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))};
            end
        end
        @(negedge pck0);
        rst = 1'b0;
        bus.cfg_valid = 1'b0;
        repeat (200) @(negedge pck0);
        check("conf_queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
